// File: rtl/display_scan_driver.sv
// display_scan_driver: time-multiplexed 7-segment driver for N_DIGITS hex digits.
// A free-running prescaler produces a scan tick every SCAN_DIV cycles. Each tick
// advances the digit index. seg/an are a single registered stage that follows the
// current index and the shadow register. Optional blink support is enabled by
// defining the macro DSCAN_BLINK_EN.
module display_scan_driver #(
  parameter int N_DIGITS     = 3,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  lzb,
`ifdef DSCAN_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  if (N_DIGITS < 1 || N_DIGITS > 8 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_bad_params
    $error("display_scan_driver: parameter out of range");
  end

  logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  tick;
  logic                  frame_wrap;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [N_DIGITS-1:0]   blank;
  logic [3:0]            nib;
  logic                  blank_cur;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0: decode = 7'h7E;
      4'h1: decode = 7'h30;
      4'h2: decode = 7'h6D;
      4'h3: decode = 7'h79;
      4'h4: decode = 7'h33;
      4'h5: decode = 7'h5B;
      4'h6: decode = 7'h5F;
      4'h7: decode = 7'h70;
      4'h8: decode = 7'h7F;
      4'h9: decode = 7'h7B;
      4'hA: decode = 7'h77;
      4'hB: decode = 7'h1F;
      4'hC: decode = 7'h4E;
      4'hD: decode = 7'h3D;
      4'hE: decode = 7'h4F;
      default: decode = 7'h47;
    endcase
  endfunction

  assign tick       = (cnt_q == CNT_W'(SCAN_DIV - 1));
  assign frame_wrap = tick && (idx_q == IDX_W'(N_DIGITS - 1));

  // Shadow capture, prescaler wrap and digit index advance.
  always_comb begin
    shadow_d = load ? digits_in : shadow_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = idx_q;
    if (tick) begin
      idx_d = frame_wrap ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero blanking: a digit above 0 is dark when it and every higher digit is zero.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (shadow_q[4*i +: 4] == 4'h0);
      lz_blank[i] = lzb && all_zero && (i != 0);
    end
  end

`ifdef DSCAN_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BF_W-1:0] bcnt_q, bcnt_d;
  logic            phase_q, phase_d;

  // Frame counter toggles the blink phase every BLINK_FRAMES completed frames.
  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (frame_wrap) begin
      if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  // Blink counter and phase registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blank = lz_blank | (phase_q ? blink_mask : '0);
`else
  assign blank = lz_blank;
`endif

  // Select the active digit and form the next segment / anode pattern.
  always_comb begin
    nib       = 4'h0;
    blank_cur = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib       = shadow_q[4*i +: 4];
        blank_cur = blank[i];
      end
    end
    seg_d = 7'h00;
    an_d  = '1;
    if (enable && !blank_cur) begin
      seg_d = decode(nib);
      an_d  = ~(N_DIGITS'(1) << idx_q);
    end
  end

  // State and output registers; reset forces outputs dark immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= 7'h00;
      an_q     <= '1;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_display_scan_driver.sv
// Testbench for display_scan_driver (N_DIGITS=3, SCAN_DIV=4, BLINK_FRAMES=2).
// Expected outputs come from an arithmetic model: the visible digit after edge k
// since reset release is ((k-1)/SCAN_DIV) mod N_DIGITS, the frame number is
// (k-1)/(SCAN_DIV*N_DIGITS), and the blink phase is (frame/BLINK_FRAMES) mod 2.
// Blink scenarios are compiled only when DSCAN_BLINK_EN is defined.
module tb_display_scan_driver;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int BF = 2;

  logic          clk;
  logic          reset;
  logic [11:0]   digits_in;
  logic          load;
  logic          enable;
  logic          lzb;
  logic [2:0]    msk;
  logic [6:0]    seg;
  logic [2:0]    an;

  int            npass;
  int            ntot;
  int            k;
  logic [11:0]   m_sh;
  logic [6:0]    exp_seg;
  logic [2:0]    exp_an;

  logic [6:0] SEG_TAB [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  display_scan_driver #(.N_DIGITS(N), .SCAN_DIV(D), .BLINK_FRAMES(BF)) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .load      (load),
    .enable    (enable),
    .lzb       (lzb),
`ifdef DSCAN_BLINK_EN
    .blink_mask(msk),
`endif
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected display after edge kk, given shadow and inputs present before that edge.
  task automatic model(input int kk, input logic [11:0] sh, input logic en, input logic lz,
                       input logic [2:0] mk, output logic [6:0] es, output logic [2:0] ea);
    int idx, frame, phase, code;
    logic dark;
    idx   = ((kk - 1) / D) % N;
    frame = (kk - 1) / (D * N);
    phase = (frame / BF) % 2;
    code  = int'((sh >> (4 * idx)) & 12'h00F);
    dark  = lz && (idx > 0) && ((sh >> (4 * idx)) == 12'h000);
`ifdef DSCAN_BLINK_EN
    if (phase == 1 && mk[idx]) dark = 1'b1;
`else
    if (phase < 0 && mk != 3'b000) dark = 1'b1;
`endif
    if (!en || dark) begin
      es = 7'h00;
      ea = 3'b111;
    end else begin
      es = SEG_TAB[code];
      ea = ~(3'b001 << idx);
    end
  endtask

  // Advance one clock, update the model, and leave time at posedge+1 for sampling.
  task automatic step();
    logic [11:0] sh_pre;
    logic        ld_s;
    logic [11:0] din_s;
    sh_pre = m_sh;
    ld_s   = load;
    din_s  = digits_in;
    model(k + 1, sh_pre, enable, lzb, msk, exp_seg, exp_an);
    @(posedge clk);
    k = k + 1;
    if (ld_s) m_sh = din_s;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; digits_in = '0; enable = 1'b0; lzb = 1'b0; msk = '0;
    repeat (2) @(posedge clk);
    #1;
    ntot++;
    if (seg !== 7'h00 || an !== 3'b111)
      $display("FAIL reset_hold: seg=%h an=%b required seg=00 an=111", seg, an);
    else npass++;
    @(negedge clk);
    reset = 1'b0; k = 0; m_sh = '0; enable = 1'b1;
    step();
    ntot++;
    if (seg !== 7'h7E || an !== 3'b110)
      $display("FAIL reset_first_digit: seg=%h an=%b required seg=7e an=110", seg, an);
    else npass++;
  endtask

  task automatic test_scan_159();
    digits_in = 12'h159; load = 1'b1; enable = 1'b1; lzb = 1'b0;
    step();
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      step();
      ntot++;
      if (seg !== exp_seg || an !== exp_an)
        $display("FAIL scan_159[%0d]: seg=%h an=%b required seg=%h an=%b", i, seg, an, exp_seg, exp_an);
      else npass++;
    end
  endtask

  task automatic test_lzb();
    digits_in = 12'h007; load = 1'b1; lzb = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (i == 12) lzb = 1'b0;
      step();
      ntot++;
      if (seg !== exp_seg || an !== exp_an)
        $display("FAIL lzb[%0d]: seg=%h an=%b required seg=%h an=%b", i, seg, an, exp_seg, exp_an);
      else npass++;
    end
  endtask

  task automatic test_enable();
    digits_in = 12'hA3C; load = 1'b1; lzb = 1'b0;
    step();
    load = 1'b0;
    step();
    enable = 1'b0;
    for (int i = 0; i < 22; i++) begin
      if (i == 10) enable = 1'b1;
      step();
      ntot++;
      if (seg !== exp_seg || an !== exp_an)
        $display("FAIL enable[%0d]: seg=%h an=%b required seg=%h an=%b", i, seg, an, exp_seg, exp_an);
      else npass++;
    end
  endtask

  task automatic test_load_on_tick();
    for (int r = 0; r < 3; r++) begin
      while ((k % D) != D - 1) step();
      digits_in = 12'($urandom); load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 2 * D; i++) begin
        step();
        ntot++;
        if (seg !== exp_seg || an !== exp_an)
          $display("FAIL load_on_tick[%0d.%0d]: seg=%h an=%b required seg=%h an=%b", r, i, seg, an, exp_seg, exp_an);
        else npass++;
      end
    end
  endtask

  task automatic test_async_reset();
    digits_in = 12'h4B2; load = 1'b1;
    step();
    load = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    ntot++;
    if (seg !== 7'h00 || an !== 3'b111)
      $display("FAIL async_reset_immediate: seg=%h an=%b required seg=00 an=111", seg, an);
    else npass++;
    @(posedge clk);
    #1;
    ntot++;
    if (seg !== 7'h00 || an !== 3'b111)
      $display("FAIL async_reset_held: seg=%h an=%b required seg=00 an=111", seg, an);
    else npass++;
    #2 reset = 1'b0;
    k = 0; m_sh = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      ntot++;
      if (seg !== exp_seg || an !== exp_an)
        $display("FAIL after_reset[%0d]: seg=%h an=%b required seg=%h an=%b", i, seg, an, exp_seg, exp_an);
      else npass++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      load      = ($urandom_range(0, 4) == 0);
      digits_in = 12'($urandom);
      if ($urandom_range(0, 2) == 0) digits_in[11:4] = 8'h00;
      if ($urandom_range(0, 15) == 0) enable = ~enable;
      if ($urandom_range(0, 15) == 0) lzb = ~lzb;
`ifdef DSCAN_BLINK_EN
      if ($urandom_range(0, 15) == 0) msk = 3'($urandom);
`endif
      step();
      ntot++;
      if (seg !== exp_seg || an !== exp_an)
        $display("FAIL random[%0d]: seg=%h an=%b required seg=%h an=%b", i, seg, an, exp_seg, exp_an);
      else npass++;
    end
    load = 1'b0; enable = 1'b1; lzb = 1'b0; msk = '0;
  endtask

`ifdef DSCAN_BLINK_EN
  task automatic test_blink();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; k = 0; m_sh = '0;
    msk = 3'b010; digits_in = 12'h888; load = 1'b1; enable = 1'b1; lzb = 1'b0;
    step();
    load = 1'b0;
    for (int i = 1; i < 6 * D * N; i++) begin
      step();
      ntot++;
      if (seg !== exp_seg || an !== exp_an)
        $display("FAIL blink[%0d]: seg=%h an=%b required seg=%h an=%b", i, seg, an, exp_seg, exp_an);
      else npass++;
    end
    msk = '0;
  endtask
`endif

  initial begin
    npass = 0; ntot = 0; k = 0; m_sh = '0;
    test_reset();
    test_scan_159();
    test_lzb();
    test_enable();
    test_load_on_tick();
    test_async_reset();
    test_random();
`ifdef DSCAN_BLINK_EN
    test_blink();
`endif
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/display_scan_driver.md
DISPLAY_SCAN_DRIVER -- requirements
Module: display_scan_driver

Interface
REQ-001 Parameter N_DIGITS, default 3, number of BCD/hex digits driven (min 1, max 8).
REQ-002 Parameter SCAN_DIV, default 50000, clock cycles each digit stays active (min 2).
REQ-003 Parameter BLINK_FRAMES, default 250, full scan frames per blink half-period (used only with DSCAN_BLINK_EN).
REQ-004 clk  input  1  system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 digits_in  input  4*N_DIGITS  digit codes; nibble i = digit i, digit 0 rightmost.
REQ-007 load  input  1  one-cycle strobe; captures digits_in into the shadow register.
REQ-008 enable  input  1  1 = scan active; 0 = all anodes off.
REQ-009 lzb  input  1  1 = leading-zero blanking on.
REQ-010 blink_mask  input  N_DIGITS  per-digit blink select (present only with DSCAN_BLINK_EN).
REQ-011 seg  output  7  segments {a,b,c,d,e,f,g} on bits 6..0, active-high, registered.
REQ-012 an  output  N_DIGITS  digit select, active-low one-hot, registered.

Function
REQ-013 Shadow register SHALL load digits_in on the clock edge where load=1 and hold otherwise; display reads only the shadow.
REQ-014 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; a scan tick SHALL occur on the cycle it equals SCAN_DIV-1.
REQ-015 Digit index SHALL advance by 1 on each scan tick, wrapping N_DIGITS-1 -> 0; one wrap = one frame.
REQ-016 seg/an SHALL reflect the current index and shadow one cycle after any change (single registered stage).
REQ-017 an SHALL drive bit[index] low and all others high when enable=1 and the digit is not blanked; otherwise all ones.
REQ-018 seg SHALL be 7'h00 whenever the active digit is blanked or enable=0.
REQ-019 Decode SHALL be: 0=7E 1=30 2=6D 3=79 4=33 5=5B 6=5F 7=70 8=7F 9=7B A=77 b=1F C=4E d=3D E=4F F=47.
REQ-020 With lzb=1, digit i>0 SHALL be blanked if digit i and all higher digits are 0; digit 0 is never lzb-blanked.
REQ-021 enable=0 SHALL not stop prescaler, index or blink counters; only outputs are forced off.
REQ-022 load coincident with a scan tick SHALL show the new value when the new index first becomes visible.
REQ-023 N_DIGITS=1 SHALL hold index at 0 with a tick counted as a frame each SCAN_DIV cycles.

Reset
REQ-024 While reset=1: shadow=0, prescaler=0, index=0, blink counter=0, blink phase=0, seg=7'h00, an=all ones.
REQ-025 Reset asserted mid-scan SHALL take effect immediately, independent of clk; first tick after release occurs SCAN_DIV cycles later.

Configuration
REQ-026 Macro DSCAN_BLINK_EN defined: blink_mask port, frame counter (0..BLINK_FRAMES-1) and phase bit exist; phase toggles on each counter wrap; digit i blanked while phase=1 and blink_mask[i]=1.
REQ-027 Macro DSCAN_BLINK_EN undefined: no blink_mask port, no blink counter or phase logic; behaviour equals REQ-013..REQ-023.

Verification (N_DIGITS=3, SCAN_DIV=4, BLINK_FRAMES=2)
REQ-028 Reset release, load digits_in=12'h159, enable=1 -> an cycles 110,101,011 every 4 cycles; seg 5B,1F? no: 7B(9),5B(5),30(1) for digits 0,1,2.
REQ-029 load 12'h007, lzb=1 -> digit0 seg=70 an=110; digits 1,2 an=111 seg=00; lzb=0 -> digits 1,2 show 7E.
REQ-030 enable=0 for 10 cycles during scan -> an=111, seg=00; re-enable -> index continues from free-running count, no restart.
REQ-031 Assert reset asynchronously mid-digit -> seg=00, an=111 before next clk edge; after release digit 0 shown after one cycle, next tick 4 cycles later.
REQ-032 DSCAN_BLINK_EN, blink_mask=3'b010, load 12'h888 -> digit1 dark in frames 2-3, lit in frames 0-1 and 4-5; digits 0,2 always 7F.
